// File: rtl/wb_pkg.sv
// Shared definitions for the writeback result stage: load encodings,
// result-source indices, FSM states and a select-width helper.
package wb_pkg;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Conventional result-source slots
  localparam int SRC_ALU  = 0;
  localparam int SRC_LOAD = 1;
  localparam int SRC_PC4  = 2;
  localparam int SRC_IMM  = 3;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } wb_state_e;

  // Width of a select/counter field for n choices, never below one bit
  function automatic int sel_w(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      return 1;
    end else begin
      return w;
    end
  endfunction

endpackage

// File: rtl/wb_result_stage_load_ext.sv
// Combinational load formatter: picks the addressed byte/half/word from a
// raw memory word, sign- or zero-extends it and flags misaligned accesses.
module load_ext
  import wb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data,
  input  logic [2:0]       funct3,
  input  logic [1:0]       off,
  output logic [WIDTH-1:0] ext_data,
  output logic             misalign
);

  logic [31:0] word_s;
  logic [15:0] half_s;
  logic [7:0]  byte_s;

  // Lane selection from the low 32 bits of the read word
  always_comb begin
    word_s = data[31:0];
    case (off)
      2'd0:    byte_s = word_s[7:0];
      2'd1:    byte_s = word_s[15:8];
      2'd2:    byte_s = word_s[23:16];
      2'd3:    byte_s = word_s[31:24];
      default: byte_s = word_s[7:0];
    endcase
    if (off[1]) begin
      half_s = word_s[31:16];
    end else begin
      half_s = word_s[15:0];
    end
  end

  // Extension by load type; unknown encodings behave like a word load
  always_comb begin
    ext_data = WIDTH'($signed(word_s));
    misalign = 1'b0;
    case (funct3)
      F3_LB: begin
        ext_data = WIDTH'($signed(byte_s));
        misalign = 1'b0;
      end
      F3_LBU: begin
        ext_data = WIDTH'(byte_s);
        misalign = 1'b0;
      end
      F3_LH: begin
        ext_data = WIDTH'($signed(half_s));
        misalign = off[0];
      end
      F3_LHU: begin
        ext_data = WIDTH'(half_s);
        misalign = off[0];
      end
      default: begin
        ext_data = WIDTH'($signed(word_s));
        misalign = (off != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/wb_result_stage.sv
// MEM/WB pipeline register with N-way result select, load formatting,
// a wait state for late memory responses and a load timeout.
module wb_result_stage
  import wb_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int NUM_SRC     = 4,
  parameter int LOAD_IDX    = 1,
  parameter int DEFAULT_IDX = 0,
  parameter int TIMEOUT     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       StallW,
  input  logic                       FlushW,
  input  logic                       ValidM,
  input  logic                       RegWriteM,
  input  logic [4:0]                 RdM,
  input  logic [sel_w(NUM_SRC)-1:0]  ResultSrcM,
  input  logic [NUM_SRC*WIDTH-1:0]   SrcDataM,
  input  logic                       LoadM,
  input  logic [2:0]                 Funct3M,
  input  logic [1:0]                 ByteOffM,
  input  logic [WIDTH-1:0]           DMemRdata,
  input  logic                       DMemRvalid,
  output logic [WIDTH-1:0]           ResultW,
  output logic [4:0]                 RdW,
  output logic                       RegWriteW,
  output logic                       ValidW,
  output logic                       LoadStallW,
  output logic                       LoadErrW,
  output logic                       MisalignW
);

  localparam int CW = sel_w(TIMEOUT + 1);

  wb_state_e        state_r, state_n;
  logic [CW-1:0]    cnt_r, cnt_n;
  logic [WIDTH-1:0] result_r, result_n;
  logic [4:0]       rd_r, rd_n;
  logic             regwrite_r, regwrite_n;
  logic             valid_r, valid_n;
  logic             load_err_r, load_err_n;
  logic             misalign_r, misalign_n;
  logic [4:0]       held_rd_r, held_rd_n;
  logic             held_rw_r, held_rw_n;
  logic [2:0]       held_f3_r, held_f3_n;
  logic [1:0]       held_off_r, held_off_n;

  logic [2:0]       fmt_f3_s;
  logic [1:0]       fmt_off_s;
  logic [WIDTH-1:0] fmt_data_s;
  logic             fmt_mis_s;
  int               sel_idx_s;
  logic [WIDTH-1:0] sel_data_s;
  logic             timeout_hit_s;

  // Formatter sees the live MEM fields in RUN and the latched ones in WAIT
  always_comb begin
    if (state_r == WAIT) begin
      fmt_f3_s  = held_f3_r;
      fmt_off_s = held_off_r;
    end else begin
      fmt_f3_s  = Funct3M;
      fmt_off_s = ByteOffM;
    end
  end

  load_ext #(.WIDTH(WIDTH)) u_load_ext (
    .data     (DMemRdata),
    .funct3   (fmt_f3_s),
    .off      (fmt_off_s),
    .ext_data (fmt_data_s),
    .misalign (fmt_mis_s)
  );

  // Result select; out-of-range selects fall back to the default source
  always_comb begin
    if (int'(ResultSrcM) < NUM_SRC) begin
      sel_idx_s = int'(ResultSrcM);
    end else begin
      sel_idx_s = DEFAULT_IDX;
    end
    if (sel_idx_s == LOAD_IDX) begin
      sel_data_s = fmt_data_s;
    end else begin
      sel_data_s = SrcDataM[sel_idx_s*WIDTH +: WIDTH];
    end
  end

  // Timeout fires on the last permitted wait cycle; zero disables it
  always_comb begin
    if (TIMEOUT != 0) begin
      timeout_hit_s = (int'(cnt_r) == TIMEOUT - 1);
    end else begin
      timeout_hit_s = 1'b0;
    end
  end

  // Upstream freeze: whole WAIT state, plus the cycle a late load is accepted
  always_comb begin
    if (state_r == WAIT) begin
      LoadStallW = 1'b1;
    end else begin
      LoadStallW = ValidM & LoadM & ~DMemRvalid & ~StallW & ~FlushW;
    end
  end

  // Next-state and next-output logic, flush taking priority over everything
  always_comb begin
    state_n    = state_r;
    cnt_n      = cnt_r;
    result_n   = result_r;
    rd_n       = rd_r;
    regwrite_n = regwrite_r;
    valid_n    = valid_r;
    load_err_n = 1'b0;
    misalign_n = misalign_r;
    held_rd_n  = held_rd_r;
    held_rw_n  = held_rw_r;
    held_f3_n  = held_f3_r;
    held_off_n = held_off_r;
    if (FlushW) begin
      valid_n    = 1'b0;
      regwrite_n = 1'b0;
      misalign_n = 1'b0;
      state_n    = RUN;
      cnt_n      = {CW{1'b0}};
    end else begin
      case (state_r)
        RUN: begin
          if (StallW) begin
            load_err_n = 1'b0;
          end else if (!ValidM) begin
            valid_n    = 1'b0;
            regwrite_n = 1'b0;
          end else if (LoadM && !DMemRvalid) begin
            held_rd_n  = RdM;
            held_rw_n  = RegWriteM;
            held_f3_n  = Funct3M;
            held_off_n = ByteOffM;
            state_n    = WAIT;
            cnt_n      = {CW{1'b0}};
            valid_n    = 1'b0;
            regwrite_n = 1'b0;
          end else begin
            result_n   = sel_data_s;
            rd_n       = RdM;
            regwrite_n = RegWriteM;
            misalign_n = LoadM & fmt_mis_s;
            valid_n    = 1'b1;
          end
        end
        WAIT: begin
          if (DMemRvalid) begin
            result_n   = fmt_data_s;
            rd_n       = held_rd_r;
            regwrite_n = held_rw_r;
            misalign_n = fmt_mis_s;
            valid_n    = 1'b1;
            state_n    = RUN;
            cnt_n      = {CW{1'b0}};
          end else if (timeout_hit_s) begin
            result_n   = {WIDTH{1'b0}};
            regwrite_n = 1'b0;
            valid_n    = 1'b1;
            load_err_n = 1'b1;
            state_n    = RUN;
            cnt_n      = {CW{1'b0}};
          end else begin
            cnt_n      = cnt_r + CW'(1'b1);
            valid_n    = 1'b0;
            regwrite_n = 1'b0;
          end
        end
        default: begin
          state_n    = RUN;
          cnt_n      = {CW{1'b0}};
          valid_n    = 1'b0;
          regwrite_n = 1'b0;
        end
      endcase
    end
  end

  // State, counter, held load fields and registered writeback outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= RUN;
      cnt_r      <= {CW{1'b0}};
      result_r   <= {WIDTH{1'b0}};
      rd_r       <= 5'd0;
      regwrite_r <= 1'b0;
      valid_r    <= 1'b0;
      load_err_r <= 1'b0;
      misalign_r <= 1'b0;
      held_rd_r  <= 5'd0;
      held_rw_r  <= 1'b0;
      held_f3_r  <= 3'd0;
      held_off_r <= 2'd0;
    end else begin
      state_r    <= state_n;
      cnt_r      <= cnt_n;
      result_r   <= result_n;
      rd_r       <= rd_n;
      regwrite_r <= regwrite_n;
      valid_r    <= valid_n;
      load_err_r <= load_err_n;
      misalign_r <= misalign_n;
      held_rd_r  <= held_rd_n;
      held_rw_r  <= held_rw_n;
      held_f3_r  <= held_f3_n;
      held_off_r <= held_off_n;
    end
  end

  assign ResultW   = result_r;
  assign RdW       = rd_r;
  assign RegWriteW = regwrite_r;
  assign ValidW    = valid_r;
  assign LoadErrW  = load_err_r;
  assign MisalignW = misalign_r;

endmodule

// File: tb/tb_wb_result_stage.sv
// Scoreboard bench for wb_result_stage: stimulus pushes expected writeback
// records and per-cycle LoadStallW values; monitors pop and compare.
module tb_wb_result_stage;
  import wb_pkg::*;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        rw;
    logic        mis;
    logic        err;
  } wrec_t;

  logic         clk, rst_n, StallW, FlushW, ValidM, ValidM3, RegWriteM, LoadM, DMemRvalid;
  logic [4:0]   RdM;
  logic [1:0]   ResultSrcM;
  logic [127:0] SrcDataM;
  logic [2:0]   Funct3M;
  logic [1:0]   ByteOffM;
  logic [31:0]  DMemRdata;

  logic [31:0]  ResultW, ResultW3;
  logic [4:0]   RdW, RdW3;
  logic         RegWriteW, ValidW, LoadStallW, LoadErrW, MisalignW;
  logic         RegWriteW3, ValidW3, LoadStallW3, LoadErrW3, MisalignW3;

  int checks = 0;
  int errors = 0;

  wrec_t exp_q[$];
  wrec_t exp3_q[$];
  logic  stall_q[$];

  logic [31:0] cur_res;
  logic [4:0]  cur_rd;
  logic        cur_rw, cur_mis;

  wb_result_stage #(.WIDTH(32), .NUM_SRC(4), .LOAD_IDX(1), .DEFAULT_IDX(0), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM),
    .RegWriteM(RegWriteM), .RdM(RdM), .ResultSrcM(ResultSrcM), .SrcDataM(SrcDataM),
    .LoadM(LoadM), .Funct3M(Funct3M), .ByteOffM(ByteOffM), .DMemRdata(DMemRdata),
    .DMemRvalid(DMemRvalid), .ResultW(ResultW), .RdW(RdW), .RegWriteW(RegWriteW),
    .ValidW(ValidW), .LoadStallW(LoadStallW), .LoadErrW(LoadErrW), .MisalignW(MisalignW)
  );

  wb_result_stage #(.WIDTH(32), .NUM_SRC(3), .LOAD_IDX(1), .DEFAULT_IDX(2), .TIMEOUT(0)) dut3 (
    .clk(clk), .rst_n(rst_n), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM3),
    .RegWriteM(RegWriteM), .RdM(RdM), .ResultSrcM(ResultSrcM), .SrcDataM(SrcDataM[95:0]),
    .LoadM(LoadM), .Funct3M(Funct3M), .ByteOffM(ByteOffM), .DMemRdata(DMemRdata),
    .DMemRvalid(DMemRvalid), .ResultW(ResultW3), .RdW(RdW3), .RegWriteW(RegWriteW3),
    .ValidW(ValidW3), .LoadStallW(LoadStallW3), .LoadErrW(LoadErrW3), .MisalignW(MisalignW3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Main monitor: per-cycle LoadStallW plus writeback records on ValidW
  always @(negedge clk) begin
    wrec_t e, a;
    logic  es;
    if (stall_q.size() > 0) begin
      es = stall_q.pop_front();
      checks++;
      if (LoadStallW !== es) begin
        errors++;
        $display("FAIL load_stall @%0t: got %b want %b", $time, LoadStallW, es);
      end
    end
    a = {ResultW, RdW, RegWriteW, MisalignW, LoadErrW};
    checks++;
    if (ValidW === 1'b1) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid @%0t: got res=%h rd=%0d rw=%b mis=%b err=%b want no output",
                 $time, a.res, a.rd, a.rw, a.mis, a.err);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL wb_out @%0t: got res=%h rd=%0d rw=%b mis=%b err=%b want res=%h rd=%0d rw=%b mis=%b err=%b",
                   $time, a.res, a.rd, a.rw, a.mis, a.err, e.res, e.rd, e.rw, e.mis, e.err);
        end
      end
    end else if (ValidW !== 1'b0 || RegWriteW !== 1'b0 || LoadErrW !== 1'b0) begin
      errors++;
      $display("FAIL idle_flags @%0t: got valid=%b rw=%b err=%b want 0 0 0", $time, ValidW, RegWriteW, LoadErrW);
    end
  end

  // Second monitor for the three-source instance
  always @(negedge clk) begin
    wrec_t e, a;
    if (ValidW3 === 1'b1) begin
      a = {ResultW3, RdW3, RegWriteW3, MisalignW3, LoadErrW3};
      checks++;
      if (exp3_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid3 @%0t: got res=%h want no output", $time, a.res);
      end else begin
        e = exp3_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL wb_out3 @%0t: got res=%h rd=%0d rw=%b want res=%h rd=%0d rw=%b",
                   $time, a.res, a.rd, a.rw, e.res, e.rd, e.rw);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic tick(input logic es);
    stall_q.push_back(es);
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    ValidM = 1'b0; ValidM3 = 1'b0; LoadM = 1'b0; StallW = 1'b0; FlushW = 1'b0;
    DMemRvalid = 1'b0; RegWriteM = 1'b0; ResultSrcM = 2'd0; Funct3M = 3'd0; ByteOffM = 2'd0;
    RdM = 5'd0; DMemRdata = 32'h80FF_7F81;
  endtask

  task automatic push_w(input logic [31:0] r, input logic [4:0] d, input logic w, input logic m, input logic e);
    exp_q.push_back({r, d, w, m, e});
    cur_res = r; cur_rd = d; cur_rw = w; cur_mis = m;
  endtask

  task automatic push_hold();
    exp_q.push_back({cur_res, cur_rd, cur_rw, cur_mis, 1'b0});
  endtask

  task automatic op_alu(input logic [1:0] s, input logic [4:0] d, input logic w, input logic [31:0] want);
    set_idle();
    ValidM = 1'b1; ResultSrcM = s; RdM = d; RegWriteM = w;
    push_w(want, d, w, 1'b0, 1'b0);
    tick(1'b0);
  endtask

  task automatic op_ld(input logic [2:0] f3, input logic [1:0] off, input logic [4:0] d,
                       input logic [31:0] want, input logic m);
    set_idle();
    ValidM = 1'b1; LoadM = 1'b1; ResultSrcM = 2'd1; RdM = d; RegWriteM = 1'b1;
    Funct3M = f3; ByteOffM = off; DMemRvalid = 1'b1;
    push_w(want, d, 1'b1, m, 1'b0);
    tick(1'b0);
  endtask

  // Presents a load whose data is not yet back; leaves inputs frozen
  task automatic op_ld_miss(input logic [2:0] f3, input logic [1:0] off, input logic [4:0] d);
    set_idle();
    ValidM = 1'b1; LoadM = 1'b1; ResultSrcM = 2'd1; RdM = d; RegWriteM = 1'b1;
    Funct3M = f3; ByteOffM = off; DMemRvalid = 1'b0;
    tick(1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();
    SrcDataM = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_1234};
    cur_res = 32'd0; cur_rd = 5'd0; cur_rw = 1'b0; cur_mis = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {22'd0, ResultW, RdW, RegWriteW, ValidW, LoadStallW, LoadErrW, MisalignW}, 64'd0);
    rst_n = 1'b1;

    // Plain source selects
    op_alu(2'd0, 5'd5, 1'b1, 32'h0000_1234);
    op_alu(2'd2, 5'd1, 1'b1, 32'h2222_2222);
    op_alu(2'd3, 5'd31, 1'b0, 32'h3333_3333);
    set_idle(); tick(1'b0);

    // Load extraction from 0x80FF_7F81
    op_ld(F3_LB,  2'd0, 5'd2, 32'hFFFF_FF81, 1'b0);
    op_ld(F3_LBU, 2'd3, 5'd3, 32'h0000_0080, 1'b0);
    op_ld(F3_LH,  2'd2, 5'd4, 32'hFFFF_80FF, 1'b0);
    op_ld(F3_LHU, 2'd0, 5'd6, 32'h0000_7F81, 1'b0);
    op_ld(F3_LB,  2'd1, 5'd8, 32'h0000_007F, 1'b0);
    op_ld(F3_LBU, 2'd2, 5'd9, 32'h0000_00FF, 1'b0);
    op_ld(F3_LW,  2'd0, 5'd10, 32'h80FF_7F81, 1'b0);
    op_ld(F3_LH,  2'd1, 5'd11, 32'h0000_7F81, 1'b1);
    op_ld(F3_LW,  2'd2, 5'd12, 32'h80FF_7F81, 1'b1);
    op_alu(2'd0, 5'd5, 1'b1, 32'h0000_1234);

    // Stall in RUN for two cycles, second with a late load presented
    op_alu(2'd0, 5'd7, 1'b1, 32'h0000_1234);
    set_idle(); StallW = 1'b1; ValidM = 1'b1; ResultSrcM = 2'd2; RdM = 5'd9; RegWriteM = 1'b1;
    push_hold(); tick(1'b0);
    set_idle(); StallW = 1'b1; ValidM = 1'b1; LoadM = 1'b1; ResultSrcM = 2'd1; RdM = 5'd9;
    RegWriteM = 1'b1; Funct3M = F3_LW;
    push_hold(); tick(1'b0);
    op_alu(2'd3, 5'd10, 1'b1, 32'h3333_3333);
    set_idle(); tick(1'b0);

    // Late word load: three empty cycles then data
    op_ld_miss(F3_LW, 2'd0, 5'd12);
    tick(1'b1);
    tick(1'b1);
    DMemRvalid = 1'b1; DMemRdata = 32'hDEAD_BEEF;
    push_w(32'hDEAD_BEEF, 5'd12, 1'b1, 1'b0, 1'b0);
    tick(1'b1);
    set_idle(); tick(1'b0);

    // Late misaligned half load; live funct3/offset change must not matter
    op_ld_miss(F3_LH, 2'd3, 5'd11);
    Funct3M = F3_LW; ByteOffM = 2'd0; DMemRvalid = 1'b1; DMemRdata = 32'h8001_0000;
    push_w(32'hFFFF_8001, 5'd11, 1'b1, 1'b1, 1'b0);
    tick(1'b1);
    set_idle(); tick(1'b0);

    // Timeout (limit 4): no data ever returns
    op_alu(2'd3, 5'd13, 1'b1, 32'h3333_3333);
    op_ld_miss(F3_LW, 2'd0, 5'd13);
    tick(1'b1);
    tick(1'b1);
    tick(1'b1);
    push_w(32'h0000_0000, 5'd13, 1'b0, 1'b0, 1'b1);
    tick(1'b1);
    set_idle(); tick(1'b0);
    tick(1'b0);

    // Flush while waiting
    op_ld_miss(F3_LW, 2'd0, 5'd14);
    FlushW = 1'b1;
    tick(1'b1);
    cur_rw = 1'b0; cur_mis = 1'b0;
    set_idle(); tick(1'b0);
    op_alu(2'd0, 5'd15, 1'b1, 32'h0000_1234);
    set_idle(); tick(1'b0);

    // Three-source instance: out-of-range select uses the default source
    set_idle(); ValidM3 = 1'b1; ResultSrcM = 2'd3; RdM = 5'd3; RegWriteM = 1'b1;
    exp3_q.push_back({32'h2222_2222, 5'd3, 1'b1, 1'b0, 1'b0});
    tick(1'b0);
    set_idle(); ValidM3 = 1'b1; ResultSrcM = 2'd0; RdM = 5'd4; RegWriteM = 1'b1;
    exp3_q.push_back({32'h0000_1234, 5'd4, 1'b1, 1'b0, 1'b0});
    tick(1'b0);
    set_idle(); tick(1'b0);

    // Asynchronous reset in the middle of a wait
    op_alu(2'd2, 5'd20, 1'b1, 32'h2222_2222);
    op_ld_miss(F3_LW, 2'd0, 5'd16);
    set_idle(); tick(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_wait", {22'd0, ResultW, RdW, RegWriteW, ValidW, LoadStallW, LoadErrW, MisalignW}, 64'd0);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    set_idle(); tick(1'b0);
    op_alu(2'd2, 5'd17, 1'b1, 32'h2222_2222);

    set_idle(); tick(1'b0);
    tick(1'b0);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("exp3_q_drained", 64'(exp3_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
